sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//   Single-clock, synchronous first-in first-out byte buffer with occupancy count.
//   Decouples a producer (push) from a consumer (pop) within one clock domain.
//   Provides full/empty status flags and a live occupancy counter.
//   Overflow and underflow attempts are ignored and never corrupt stored data.
// PARAMETERS
//   DATA_WIDTH  8  width of data_in / data_out in bits
//   BUF_WIDTH   3  address bits; depth BUF_SIZE = 2**BUF_WIDTH = 8 entries
// PORTS
//   clk           in   1             rising-edge clock, the only clock
//   rst           in   1             synchronous, active-high reset
//   push          in   1             write request; data_in is captured on the clk edge
//   pop           in   1             read request; data_out is updated on the clk edge
//   data_in       in   DATA_WIDTH    write data
//   data_out      out  DATA_WIDTH    registered read data
//   empty         out  1             high when fifo_counter == 0
//   full          out  1             high when fifo_counter == BUF_SIZE
//   fifo_counter  out  BUF_WIDTH+1   number of stored entries, range 0..BUF_SIZE
// BEHAVIOUR
// - Interface: one clock, clk; reset is synchronous and active-high, named rst.
// - Reset (rst=1 at posedge clk):
//   - fifo_counter=0, empty=1, full=0, data_out=0.
//   - Read and write pointers are set to 0. Memory contents are don't-care.
//   - rst has priority over push and pop. A reset mid-stream discards all stored entries.
// - Flags:
//   - empty and full are decoded combinationally from fifo_counter.
//   - They are valid in the same cycle the count changes.
// - Write acceptance: wr_en = push & ~full, using flag values before the edge.
//   - When wr_en, at posedge: mem[wr_ptr] <= data_in and wr_ptr increments.
//   - push while full is silently dropped; memory, pointers and count are unchanged.
// - Read acceptance: rd_en = pop & ~empty.
//   - When rd_en, at posedge: data_out <= mem[rd_ptr] and rd_ptr increments.
//   - Read latency is 1 clock; data_out is valid the cycle after the pop edge.
//   - pop while empty is ignored; data_out holds its last value.
//   - data_out holds its value whenever no read occurs.
// - Pointers:
//   - BUF_WIDTH bits each; they wrap naturally from BUF_SIZE-1 to 0.
//   - No full-depth bypass: a word written in cycle N is readable at the earliest in cycle N+1.
// - Counter update per edge:
//   - wr_en only: +1. rd_en only: -1.
//   - Both or neither: unchanged.
// - Simultaneous push and pop:
//   - Not empty and not full: both occur; the count is unchanged.
//   - When empty: only the write occurs; data_out is not updated.
//   - When full: only the read occurs; the pushed word is dropped.
// - Level-sensitive handshake: each edge with push=1 is one request.
//   - Holding push high for k edges attempts k writes.
// TESTING
// - Reset: assert rst for one edge -> fifo_counter=0, empty=1, full=0, data_out=8'h00.
// - Fill: push FF,F0,FA,AA,F1,0F,F5,05 one per edge.
//   - fifo_counter steps 1..8.
//   - empty falls after the 1st push; full rises after the 8th.
// - Overflow: with the FIFO full, push 15,00,FF -> fifo_counter stays 8, full stays 1, contents unchanged.
// - Drain: 8 pops -> data_out = FF,F0,FA,AA,F1,0F,F5,05 in order.
//   - full clears after the 1st pop; empty sets after the 8th.
// - Underflow: 3 further pops while empty -> data_out holds 05, fifo_counter stays 0.
// - Wrap and simultaneous: push 5, pop 5, then push 6 to cross the pointer wrap.
//   - Push and pop together for 4 edges -> count is constant and data stays in FIFO order.
//   - rst mid-stream -> empty=1 on the next cycle.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-in first-out buffer with an occupancy counter.
//   It decouples a producer (push) from a consumer (pop) in one clock domain.
//   A push while full and a pop while empty are ignored.
//   Stored data is never disturbed by either of them.
//
// Parameters
//   DATA_WIDTH  width of data_in / data_out
//   BUF_WIDTH   address bits; depth is 2**BUF_WIDTH entries
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset; it has priority over push and pop
//   push          write request; data_in is captured on the edge when not full
//   pop           read request; data_out is loaded on the edge when not empty
//   data_in       write data
//   data_out      registered read data; it holds its value when no read occurs
//   empty         fifo_counter == 0, decoded combinationally
//   full          fifo_counter == depth, decoded combinationally
//   fifo_counter  number of stored entries, 0..depth
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic [BUF_WIDTH:0]    fifo_counter
);

  localparam int                 BUF_SIZE = 1 << BUF_WIDTH;
  localparam logic [BUF_WIDTH:0] CNT_FULL = (BUF_WIDTH+1)'(BUF_SIZE);

  logic [DATA_WIDTH-1:0] mem [BUF_SIZE];
  logic [BUF_WIDTH-1:0]  wr_ptr;
  logic [BUF_WIDTH-1:0]  rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  // The occupancy changes only when exactly one of the two transfers happens.
  function automatic logic [BUF_WIDTH:0] next_count(
    input logic [BUF_WIDTH:0] cnt,
    input logic               wr,
    input logic               rd
  );
    logic [BUF_WIDTH:0] res;
    res = cnt;
    case ({wr, rd})
      2'b10:   res = cnt + (BUF_WIDTH+1)'(1);
      2'b01:   res = cnt - (BUF_WIDTH+1)'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction

  // Pointers are exactly BUF_WIDTH bits wide.
  // They wrap from BUF_SIZE-1 to 0 without extra logic.
  function automatic logic [BUF_WIDTH-1:0] next_ptr(
    input logic [BUF_WIDTH-1:0] ptr,
    input logic                 adv
  );
    return adv ? ptr + BUF_WIDTH'(1) : ptr;
  endfunction

  assign empty = (fifo_counter == '0);
  assign full  = (fifo_counter == CNT_FULL);

  // Acceptance uses the flags from before the edge.
  // A simultaneous push and pop on an empty FIFO therefore only writes.
  // On a full FIFO it only reads.
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  // ---- edge: control state (pointers, count) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
    end else begin
      wr_ptr       <= next_ptr(wr_ptr, wr_en);
      rd_ptr       <= next_ptr(rd_ptr, rd_en);
      fifo_counter <= next_count(fifo_counter, wr_en, rd_en);
    end
  end

  // ---- edge: storage write (contents are don't-care after reset) ----
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // ---- edge: registered read port, one clock latency ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_en) begin
      data_out <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int BW    = 3;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
  logic [BW:0]   fifo_counter;

  int total = 0;
  int bad   = 0;

  // Behavioural reference: a queue of stored bytes plus the last value read.
  logic [DW-1:0] ref_q[$];
  logic [DW-1:0] ref_dout;

  sync_fifo #(.DATA_WIDTH(DW), .BUF_WIDTH(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .fifo_counter (fifo_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, 32'(fifo_counter), 32'(ref_q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(ref_q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(ref_q.size() == DEPTH));
    chk({tag, ".dout"},  32'(data_out), 32'(ref_dout));
  endtask

  // Apply one edge worth of inputs, advance the model, then check 1 time unit after the edge.
  task automatic step(input string tag, input logic r, input logic pu, input logic po,
                      input logic [DW-1:0] d);
    bit do_wr;
    bit do_rd;
    rst     = r;
    push    = pu;
    pop     = po;
    data_in = d;
    @(posedge clk);
    if (r) begin
      ref_q.delete();
      ref_dout = '0;
    end else begin
      do_wr = pu && (ref_q.size() < DEPTH);
      do_rd = po && (ref_q.size() > 0);
      if (do_rd) ref_dout = ref_q.pop_front();
      if (do_wr) ref_q.push_back(d);
    end
    #1;
    chk_all(tag);
  endtask

  logic [DW-1:0] fill_pat [DEPTH];
  logic [DW-1:0] ovf_pat  [3];

  initial begin
    fill_pat = '{8'hFF, 8'hF0, 8'hFA, 8'hAA, 8'hF1, 8'h0F, 8'hF5, 8'h05};
    ovf_pat  = '{8'h15, 8'h00, 8'hFF};
    rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    ref_dout = '0;

    // Reset
    step("reset", 1'b1, 1'b0, 1'b0, 8'h00);
    chk("reset.dout_zero", 32'(data_out), 32'h00);
    chk("reset.empty_hi", 32'(empty), 32'd1);

    // Fill
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, 1'b0, fill_pat[i]);
    chk("fill.full_hi", 32'(full), 32'd1);
    chk("fill.count8", 32'(fifo_counter), 32'd8);

    // Overflow
    for (int i = 0; i < 3; i++) step("overflow", 1'b0, 1'b1, 1'b0, ovf_pat[i]);

    // Drain, with the required order checked against the literal pattern as well
    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain.order", 32'(data_out), 32'(fill_pat[i]));
    end
    chk("drain.empty_hi", 32'(empty), 32'd1);

    // Underflow
    for (int i = 0; i < 3; i++) step("underflow", 1'b0, 1'b0, 1'b1, 8'h00);
    chk("underflow.hold05", 32'(data_out), 32'h05);

    // Wrap: push 5, pop 5, push 6 so the write pointer crosses the end
    for (int i = 0; i < 5; i++) step("wrap.push5", 1'b0, 1'b1, 1'b0, DW'(8'h30 + i));
    for (int i = 0; i < 5; i++) step("wrap.pop5", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) step("wrap.push6", 1'b0, 1'b1, 1'b0, DW'(8'h50 + i));

    // Simultaneous push and pop, count constant at 6
    for (int i = 0; i < 4; i++) begin
      step("simul", 1'b0, 1'b1, 1'b1, DW'(8'hA0 + i));
      chk("simul.count6", 32'(fifo_counter), 32'd6);
    end

    // Simultaneous on empty: only write. On full: only read.
    step("rst.mid", 1'b1, 1'b1, 1'b1, 8'h77);
    chk("rst.mid_empty", 32'(empty), 32'd1);
    step("simul.empty", 1'b0, 1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 7; i++) step("refill", 1'b0, 1'b1, 1'b0, DW'(8'hC0 + i));
    step("simul.full", 1'b0, 1'b1, 1'b1, 8'hEE);
    chk("simul.full_read", 32'(data_out), 32'h3C);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(63) == 0), 1'($urandom), 1'($urandom), DW'($urandom));
    end

    // Drain what remains so the last entries are checked in order
    for (int i = 0; i < DEPTH + 1; i++) step("final.drain", 1'b0, 1'b0, 1'b1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
